led_blink_sequencer: RTL
========================

# led_blink_sequencer

Programmable LED blink controller built on a shared prescaler tick. It sequences a configurable period/high-time waveform for a fixed number of pulses or continuously. Configuration is loaded over a valid/ready handshake and the sequence is driven by start/stop commands. It sits between board-level control logic and the LED pin, and replaces fixed-ratio divider instances.

## Interface
- CNT_W, 8, width of period/high-time fields, in ticks
- PRESCALE, 1, clk cycles per tick; must be ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready; high only in IDLE
- cfg_period  in  CNT_W  waveform period in ticks; 0 is latched as 1
- cfg_high  in  CNT_W  LED high time in ticks; values ≥ period give a constant-high LED
- cfg_count  in  4  pulses per run; 0 means continuous
- start  in  1  begin sequence, honoured only in IDLE
- stop  in  1  abort sequence, honoured only in RUN
- led  out  1  LED drive
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion

## Operation
- Reset: state=IDLE; period_r=10, high_r=5, count_r=0; prescaler pc=0, phase ph=0, pulse counter np=0.
- Reset outputs: led=0, busy=0, done=0, cfg_ready=1.
- States:
  - IDLE: cfg_ready=1, led=0. A handshake latches period_r/high_r/count_r, with period 0 forced to 1.
  - IDLE→RUN: start=1. pc, ph and np clear to 0.
  - If cfg handshake and start occur in the same cycle, the run uses the newly latched config.
  - RUN:
    - pc counts 0..PRESCALE-1 and wraps; tick = (pc==PRESCALE-1).
    - On tick, ph increments. At ph==period_r-1, ph wraps to 0 and np increments.
    - led = (ph < high_r), driven combinationally from registered state.
  - RUN→DONE: tick, ph==period_r-1, count_r!=0, and np+1==count_r.
  - RUN→IDLE: stop=1. stop has priority over a simultaneous tick or completion, and done is not pulsed.
  - DONE: one cycle, done=1, led=0, busy=1; then IDLE.
- count_r=0: RUN continues until stop. np wraps at 4 bits with no effect.
- start outside IDLE, stop outside RUN, and cfg_valid outside IDLE are ignored. Config held in cfg_* is not consumed until IDLE.
- high_r=0: led stays 0 for the whole run, while timing and done behave normally.
- rst mid-run: next cycle is IDLE with reset config values; any in-progress pulse is discarded.

## Timing
- start sampled at edge E0: RUN from E0, and led reflects ph=0 in the cycle after E0.
- Each ph value lasts exactly PRESCALE clk cycles.
- One period lasts period_r×PRESCALE cycles. A run of N pulses enters DONE at edge E0 + N×period_r×PRESCALE and returns to IDLE one edge later.
- stop sampled at edge Es: led=0 and busy=0 from Es.
- cfg_ready deasserts from E0 and reasserts in the cycle IDLE resumes.
- Back-to-back: start may be accepted in the first IDLE cycle after DONE.
- Counter widths:
  - pc is ceil(log2(PRESCALE)) bits, minimum 1.
  - ph is CNT_W bits and never exceeds period_r-1.

## Test plan
- Reset defaults: rst, then start with PRESCALE=1. Expect led high 5 cycles, low 5 cycles, repeating, busy=1, done never asserts. This matches the legacy 10-cycle, 50% divider.
- Counted run: PRESCALE=10, cfg 4/2/3, start at E0.
  - led high for 20 cycles, low for 20 cycles, ×3.
  - done=1 exactly in the cycle after E120.
  - busy=0 from E121.
- Stop mid-run:
  - continuous run (count 0), assert stop during a high phase: led=0 and busy=0 on the next cycle, done stays 0.
  - stop coincident with final tick of a counted run: done stays 0.
- Edge configs:
  - period 0, high 0, count 1: RUN lasts PRESCALE cycles, led stays 0.
  - period 3, high 7: led is constant high for the whole run.
- Handshake: cfg_valid held during RUN gives cfg_ready=0 and the config is not taken. It is accepted in the first IDLE cycle. Same-cycle cfg+start runs with the new values.
- Reset mid-run: assert rst during RUN. Next cycle state=IDLE, led=0, done=0, and config is back to 10/5/0.

Source files
------------

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer
// Programmable LED blink controller. A prescaler divides clk into ticks.
// A phase counter walks 0..period_r-1 on each tick, and the LED is high
// while the phase is below high_r. A run either repeats forever
// (count_r == 0) or ends after count_r pulses with a one-cycle done pulse.
// Configuration is loaded through a valid/ready handshake that is open
// only while the sequencer is idle.

module led_blink_sequencer #(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [3:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0]  PC_LAST        = PC_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE            = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(10);
  localparam logic [CNT_W-1:0] DEFAULT_HIGH   = CNT_W'(5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic [3:0]       count_r;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] ph;
  logic [3:0]       np;

  logic tick;
  logic period_end;
  logic last_pulse;

  assign tick       = (pc == PC_LAST);
  assign period_end = (ph == (period_r - ONE));
  assign last_pulse = (count_r != 4'd0) && ((np + 4'd1) == count_r);

  // Sequencer FSM: config latch, prescaler, phase and pulse counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      period_r <= DEFAULT_PERIOD;
      high_r   <= DEFAULT_HIGH;
      count_r  <= 4'd0;
      pc       <= '0;
      ph       <= '0;
      np       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            period_r <= (cfg_period == '0) ? ONE : cfg_period;
            high_r   <= cfg_high;
            count_r  <= cfg_count;
          end
          if (start) begin
            state <= RUN;
            pc    <= '0;
            ph    <= '0;
            np    <= 4'd0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            pc <= tick ? '0 : pc + PC_W'(1);
            if (tick) begin
              if (period_end) begin
                ph <= '0;
                np <= np + 4'd1;
                if (last_pulse) begin
                  state <= DONE;
                end
              end else begin
                ph <= ph + ONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign led       = (state == RUN) && (ph < high_r);

endmodule
